// File: rtl/divider_pkg.sv
// Shared state encoding and datapath widths for the divider arbiter.
package divider_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_FLUSH,
    ST_RESP
  } state_t;

  localparam int DIV_DW = 64;
  localparam int DIV_QW = 32;
  localparam logic [DIV_QW-1:0] DIV_ERR_Q = 32'hFFFF_FFFF;

endpackage

// File: rtl/divider_arbiter_rr.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [TAG_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant
);

  int   idx;
  logic found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/divider_arbiter.sv
// Shares one divider between NUM_REQ clients: round-robin grant, operand capture,
// start pulse, done/timeout tracking and a tagged response held until accepted.
module divider_arbiter
  import divider_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = 2,
  parameter int TIMEOUT = 80
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DIV_DW-1:0] req_dividend,
  input  logic [NUM_REQ*DIV_DW-1:0] req_divisor,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DIV_QW-1:0]         rsp_quotient,
  output logic [TAG_W-1:0]          rsp_id,
  output logic                      rsp_err,
  output logic                      div_en,
  output logic [DIV_DW-1:0]         div_dividend,
  output logic [DIV_DW-1:0]         div_divisor,
  output logic                      div_reset,
  input  logic [DIV_QW-1:0]         div_quotient,
  input  logic                      div_done
);

  localparam int TMR_W = $clog2(TIMEOUT);

  state_t             state_q, state_d;
  logic [TAG_W-1:0]   ptr_q, ptr_d;
  logic [TAG_W-1:0]   id_q, id_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [DIV_DW-1:0]  dividend_q, dividend_d;
  logic [DIV_DW-1:0]  divisor_q, divisor_d;
  logic [DIV_QW-1:0]  quot_q, quot_d;
  logic               err_q, err_d;
  logic               div_reset_q, div_reset_d;

  logic [DIV_DW-1:0]  dividend_arr [NUM_REQ];
  logic [DIV_DW-1:0]  divisor_arr  [NUM_REQ];
  logic [NUM_REQ-1:0] grant;
  logic [TAG_W-1:0]   grant_idx;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign dividend_arr[gi] = req_dividend[DIV_DW*gi +: DIV_DW];
    assign divisor_arr[gi]  = req_divisor[DIV_DW*gi +: DIV_DW];
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .TAG_W   (TAG_W)
  ) u_rr (
    .req   (req_valid),
    .ptr   (ptr_q),
    .grant (grant)
  );

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) grant_idx = TAG_W'(i);
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    id_d       = id_q;
    timer_d    = timer_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    quot_d     = quot_q;
    err_d      = err_q;
    req_ready  = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (|grant) begin
          req_ready  = grant;
          id_d       = grant_idx;
          dividend_d = dividend_arr[grant_idx];
          divisor_d  = divisor_arr[grant_idx];
          // A zero divisor never reaches the core; answer straight away.
          if (divisor_arr[grant_idx] == '0) begin
            quot_d  = DIV_ERR_Q;
            err_d   = 1'b1;
            state_d = ST_RESP;
          end else begin
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        timer_d = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        timer_d = timer_q + 1'b1;
        if (div_done) begin
          quot_d  = div_quotient;
          err_d   = 1'b0;
          state_d = ST_RESP;
        end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        quot_d  = '0;
        err_d   = 1'b1;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          ptr_d   = (id_q == TAG_W'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    div_reset_d = (state_d == ST_FLUSH);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      id_q        <= '0;
      timer_q     <= '0;
      dividend_q  <= '0;
      divisor_q   <= '0;
      quot_q      <= '0;
      err_q       <= 1'b0;
      div_reset_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      id_q        <= id_d;
      timer_q     <= timer_d;
      dividend_q  <= dividend_d;
      divisor_q   <= divisor_d;
      quot_q      <= quot_d;
      err_q       <= err_d;
      div_reset_q <= div_reset_d;
    end
  end

  assign div_en       = (state_q == ST_ISSUE);
  assign div_dividend = dividend_q;
  assign div_divisor  = divisor_q;
  assign div_reset    = div_reset_q;
  assign rsp_valid    = (state_q == ST_RESP);
  assign rsp_quotient = quot_q;
  assign rsp_id       = id_q;
  assign rsp_err      = err_q;

endmodule

// File: tb/tb_divider_arbiter.sv
// Scenario bench for divider_arbiter with a behavioural divider stub and a response scoreboard.
module tb_divider_arbiter;

  localparam int NUM_REQ = 4;
  localparam int TAG_W   = 2;
  localparam int TIMEOUT = 80;

  typedef struct {
    logic [31:0]      q;
    logic [TAG_W-1:0] id;
    logic             err;
  } exp_t;

  logic                  clk = 1'b0;
  logic                  reset_n = 1'b0;
  logic [NUM_REQ-1:0]    req_valid = '0;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*64-1:0] req_dividend = '0;
  logic [NUM_REQ*64-1:0] req_divisor = '0;
  logic                  rsp_valid;
  logic                  rsp_ready = 1'b1;
  logic [31:0]           rsp_quotient;
  logic [TAG_W-1:0]      rsp_id;
  logic                  rsp_err;
  logic                  div_en;
  logic [63:0]           div_dividend;
  logic [63:0]           div_divisor;
  logic                  div_reset;
  logic [31:0]           div_quotient = '0;
  logic                  div_done = 1'b0;

  int   tests_run = 0;
  int   tests_failed = 0;
  exp_t sb[$];
  int   div_en_cnt = 0;

  divider_arbiter #(
    .NUM_REQ (NUM_REQ),
    .TAG_W   (TAG_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_dividend (req_dividend),
    .req_divisor  (req_divisor),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_quotient (rsp_quotient),
    .rsp_id       (rsp_id),
    .rsp_err      (rsp_err),
    .div_en       (div_en),
    .div_dividend (div_dividend),
    .div_divisor  (div_divisor),
    .div_reset    (div_reset),
    .div_quotient (div_quotient),
    .div_done     (div_done)
  );

  always #5 clk = ~clk;

  // Divider stub: done N cycles after div_en; stub_n==0 never finishes.
  int          stub_n = 66;
  int          stub_cnt = 0;
  logic        stub_busy = 1'b0;
  logic [63:0] stub_a = '0;
  logic [63:0] stub_b = '0;
  logic [63:0] stub_full;

  always @(posedge clk) begin
    div_done <= 1'b0;
    if (div_en) div_en_cnt <= div_en_cnt + 1;
    if (div_reset) begin
      stub_busy <= 1'b0;
    end else if (div_en) begin
      stub_busy <= 1'b1;
      stub_cnt  <= 1;
      stub_a    <= div_dividend;
      stub_b    <= div_divisor;
    end else if (stub_busy && stub_n > 0) begin
      if (stub_cnt >= stub_n) begin
        stub_full = stub_a / stub_b;
        div_quotient <= stub_full[31:0];
        div_done     <= 1'b1;
        stub_busy    <= 1'b0;
      end else begin
        stub_cnt <= stub_cnt + 1;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  function automatic exp_t mk_exp(input logic [63:0] a, input logic [63:0] b, input int id);
    exp_t e;
    logic [63:0] full;
    if (b == 64'd0) begin
      e.q   = 32'hFFFF_FFFF;
      e.err = 1'b1;
    end else begin
      full  = a / b;
      e.q   = full[31:0];
      e.err = 1'b0;
    end
    e.id = TAG_W'(id);
    return e;
  endfunction

  task automatic set_op(input int i, input logic [63:0] a, input logic [63:0] b);
    req_dividend[64*i +: 64] = a;
    req_divisor[64*i +: 64]  = b;
  endtask

  // Advance at least one cycle, then stop on the first negedge with rsp_valid.
  task automatic wait_rsp(input int budget, output int cycles, output bit ok);
    cycles = 0;
    ok = 1'b0;
    while (cycles < budget && !ok) begin
      @(negedge clk);
      cycles++;
      if (rsp_valid) ok = 1'b1;
    end
  endtask

  task automatic wait_grant(input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget && !ok; c++) begin
      #1;
      if (req_ready != '0) ok = 1'b1;
      else @(negedge clk);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({rsp_valid, div_en, div_reset, req_ready, div_dividend, div_divisor, rsp_quotient, rsp_id, rsp_err}
        !== {1'b0, 1'b0, 1'b1, 4'b0, 64'd0, 64'd0, 32'd0, 2'd0, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_values: rsp_valid=%b div_en=%b div_reset=%b req_ready=%b q=%h, required 0 0 1 0000 0",
               rsp_valid, div_en, div_reset, req_ready, rsp_quotient);
    end
    reset_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if (div_reset !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_release_div_reset: got %b, required 0", div_reset);
    end
    $display("[TB] reset checked");
  endtask

  task automatic test_back_to_back;
    exp_t e;
    int cyc;
    bit ok;
    int en0;
    stub_n = 5;
    en0 = div_en_cnt;
    for (int i = 0; i < NUM_REQ; i++) set_op(i, 64'(1000 * (i + 1) + i), 64'(i + 3));
    for (int k = 0; k < 5; k++) sb.push_back(mk_exp(64'(1000 * ((k % 4) + 1) + (k % 4)), 64'((k % 4) + 3), k % 4));
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_rsp(60, cyc, ok);
      if (k == 4) req_valid = '0;
      e = sb.pop_front();
      tests_run++;
      if (!ok || {rsp_quotient, rsp_id, rsp_err} !== {e.q, e.id, e.err}) begin
        tests_failed++;
        $display("FAIL rr_order[%0d]: got valid=%b q=%h id=%0d err=%b, required q=%h id=%0d err=%b",
                 k, ok, rsp_quotient, rsp_id, rsp_err, e.q, e.id, e.err);
      end
      $display("[TB] rr rsp %0d id=%0d q=%h err=%b", k, rsp_id, rsp_quotient, rsp_err);
    end
    @(negedge clk);
    tests_run++;
    if (div_en_cnt - en0 !== 5) begin
      tests_failed++;
      $display("FAIL rr_div_en_count: got %0d, required 5", div_en_cnt - en0);
    end
  endtask

  task automatic test_basic;
    exp_t e;
    int c;
    bit ok;
    stub_n = 66;
    set_op(0, 64'd100, 64'd7);
    sb.push_back(mk_exp(64'd100, 64'd7, 0));
    req_valid = 4'b0001;
    wait_grant(10, ok);
    tests_run++;
    if (req_ready !== 4'b0001) begin
      tests_failed++;
      $display("FAIL basic_grant: req_ready=%b, required 0001", req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    tests_run++;
    if ({req_ready, div_en} !== {4'b0000, 1'b1}) begin
      tests_failed++;
      $display("FAIL basic_issue: req_ready=%b div_en=%b, required 0000 1", req_ready, div_en);
    end
    @(negedge clk);
    tests_run++;
    if (div_en !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_div_en_width: div_en=%b, required 0", div_en);
    end
    c = 0;
    while (!div_done && c < 200) begin
      @(negedge clk);
      c++;
    end
    @(negedge clk);
    e = sb.pop_front();
    tests_run++;
    if ({rsp_valid, rsp_quotient, rsp_id, rsp_err} !== {1'b1, e.q, e.id, e.err}) begin
      tests_failed++;
      $display("FAIL basic_rsp: valid=%b q=%h id=%0d err=%b, required 1 q=%h id=%0d err=%b",
               rsp_valid, rsp_quotient, rsp_id, rsp_err, e.q, e.id, e.err);
    end
    $display("[TB] basic rsp id=%0d q=%h err=%b", rsp_id, rsp_quotient, rsp_err);
  endtask

  task automatic test_zero_div;
    exp_t e;
    bit ok;
    int en0;
    en0 = div_en_cnt;
    set_op(2, 64'd55, 64'd0);
    sb.push_back(mk_exp(64'd55, 64'd0, 2));
    req_valid = 4'b0100;
    wait_grant(10, ok);
    tests_run++;
    if (req_ready !== 4'b0100) begin
      tests_failed++;
      $display("FAIL zero_grant: req_ready=%b, required 0100", req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    e = sb.pop_front();
    tests_run++;
    if ({rsp_valid, rsp_quotient, rsp_id, rsp_err} !== {1'b1, e.q, e.id, e.err}) begin
      tests_failed++;
      $display("FAIL zero_rsp: valid=%b q=%h id=%0d err=%b, required 1 q=%h id=%0d err=%b",
               rsp_valid, rsp_quotient, rsp_id, rsp_err, e.q, e.id, e.err);
    end
    $display("[TB] zero rsp id=%0d q=%h err=%b", rsp_id, rsp_quotient, rsp_err);
    @(negedge clk);
    tests_run++;
    if ({rsp_valid, div_en_cnt} !== {1'b0, en0}) begin
      tests_failed++;
      $display("FAIL zero_no_div_en: rsp_valid=%b div_en pulses=%0d, required 0 and %0d", rsp_valid, div_en_cnt, en0);
    end
  endtask

  task automatic test_backpressure;
    exp_t e;
    int cyc;
    bit ok;
    logic [31:0] q0;
    logic [TAG_W-1:0] id0;
    logic err0;
    stub_n = 5;
    rsp_ready = 1'b0;
    set_op(1, 64'd5000, 64'd9);
    sb.push_back(mk_exp(64'd5000, 64'd9, 1));
    req_valid = 4'b0010;
    wait_grant(10, ok);
    tests_run++;
    if (req_ready !== 4'b0010) begin
      tests_failed++;
      $display("FAIL bp_grant: req_ready=%b, required 0010", req_ready);
    end
    @(negedge clk);
    set_op(3, 64'd900, 64'd30);
    sb.push_back(mk_exp(64'd900, 64'd30, 3));
    req_valid = 4'b1000;
    wait_rsp(40, cyc, ok);
    e = sb.pop_front();
    q0 = rsp_quotient;
    id0 = rsp_id;
    err0 = rsp_err;
    tests_run++;
    if (!ok || {rsp_quotient, rsp_id, rsp_err} !== {e.q, e.id, e.err}) begin
      tests_failed++;
      $display("FAIL bp_rsp: valid=%b q=%h id=%0d err=%b, required q=%h id=%0d err=%b",
               ok, rsp_quotient, rsp_id, rsp_err, e.q, e.id, e.err);
    end
    $display("[TB] bp rsp id=%0d q=%h err=%b", rsp_id, rsp_quotient, rsp_err);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      tests_run++;
      if ({rsp_valid, rsp_quotient, rsp_id, rsp_err, req_ready, div_en} !== {1'b1, q0, id0, err0, 4'b0000, 1'b0}) begin
        tests_failed++;
        $display("FAIL bp_hold[%0d]: valid=%b q=%h id=%0d err=%b req_ready=%b div_en=%b, required stable and idle",
                 k, rsp_valid, rsp_quotient, rsp_id, rsp_err, req_ready, div_en);
      end
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    tests_run++;
    if (req_ready !== 4'b1000) begin
      tests_failed++;
      $display("FAIL bp_next_grant: req_ready=%b, required 1000", req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    wait_rsp(40, cyc, ok);
    e = sb.pop_front();
    tests_run++;
    if (!ok || {rsp_quotient, rsp_id, rsp_err} !== {e.q, e.id, e.err}) begin
      tests_failed++;
      $display("FAIL bp_second_rsp: valid=%b q=%h id=%0d err=%b, required q=%h id=%0d err=%b",
               ok, rsp_quotient, rsp_id, rsp_err, e.q, e.id, e.err);
    end
    $display("[TB] bp rsp id=%0d q=%h err=%b", rsp_id, rsp_quotient, rsp_err);
  endtask

  task automatic test_timeout;
    exp_t e;
    int c;
    int cyc;
    bit ok;
    stub_n = 0;
    set_op(0, 64'd300, 64'd3);
    e.q = 32'd0;
    e.id = 2'd0;
    e.err = 1'b1;
    sb.push_back(e);
    req_valid = 4'b0001;
    wait_grant(10, ok);
    @(negedge clk);
    req_valid = '0;
    tests_run++;
    if (div_en !== 1'b1) begin
      tests_failed++;
      $display("FAIL to_issue: div_en=%b, required 1", div_en);
    end
    c = 0;
    while (!div_reset && c < 200) begin
      @(negedge clk);
      c++;
    end
    tests_run++;
    if (c !== TIMEOUT + 1) begin
      tests_failed++;
      $display("FAIL to_flush_delay: div_reset after %0d cycles, required %0d", c, TIMEOUT + 1);
    end
    @(negedge clk);
    e = sb.pop_front();
    tests_run++;
    if ({div_reset, rsp_valid, rsp_quotient, rsp_id, rsp_err} !== {1'b0, 1'b1, e.q, e.id, e.err}) begin
      tests_failed++;
      $display("FAIL to_rsp: div_reset=%b valid=%b q=%h id=%0d err=%b, required 0 1 q=%h id=%0d err=%b",
               div_reset, rsp_valid, rsp_quotient, rsp_id, rsp_err, e.q, e.id, e.err);
    end
    $display("[TB] timeout rsp id=%0d q=%h err=%b", rsp_id, rsp_quotient, rsp_err);
    stub_n = 5;
    set_op(1, 64'd77, 64'd7);
    sb.push_back(mk_exp(64'd77, 64'd7, 1));
    req_valid = 4'b0010;
    wait_grant(10, ok);
    @(negedge clk);
    req_valid = '0;
    wait_rsp(40, cyc, ok);
    e = sb.pop_front();
    tests_run++;
    if (!ok || {rsp_quotient, rsp_id, rsp_err} !== {e.q, e.id, e.err}) begin
      tests_failed++;
      $display("FAIL to_recover: valid=%b q=%h id=%0d err=%b, required q=%h id=%0d err=%b",
               ok, rsp_quotient, rsp_id, rsp_err, e.q, e.id, e.err);
    end
    $display("[TB] recover rsp id=%0d q=%h err=%b", rsp_id, rsp_quotient, rsp_err);
  endtask

  task automatic test_reset_mid;
    exp_t e;
    int cyc;
    bit ok;
    stub_n = 66;
    set_op(0, 64'd4000, 64'd8);
    req_valid = 4'b0001;
    wait_grant(10, ok);
    @(negedge clk);
    set_op(1, 64'd1234, 64'd2);
    sb.push_back(mk_exp(64'd1234, 64'd2, 1));
    req_valid = 4'b0010;
    repeat (20) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    tests_run++;
    if ({rsp_valid, div_en, div_reset, div_dividend, div_divisor, rsp_quotient, rsp_id, rsp_err}
        !== {1'b0, 1'b0, 1'b1, 64'd0, 64'd0, 32'd0, 2'd0, 1'b0}) begin
      tests_failed++;
      $display("FAIL mid_reset_async: valid=%b div_en=%b div_reset=%b dvd=%h dvs=%h, required 0 0 1 0 0",
               rsp_valid, div_en, div_reset, div_dividend, div_divisor);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1;
    tests_run++;
    if ({req_ready, div_reset} !== {4'b0010, 1'b1}) begin
      tests_failed++;
      $display("FAIL mid_reset_regrant: req_ready=%b div_reset=%b, required 0010 1", req_ready, div_reset);
    end
    @(negedge clk);
    req_valid = '0;
    tests_run++;
    if ({div_reset, div_en} !== {1'b0, 1'b1}) begin
      tests_failed++;
      $display("FAIL mid_reset_issue: div_reset=%b div_en=%b, required 0 1", div_reset, div_en);
    end
    wait_rsp(100, cyc, ok);
    e = sb.pop_front();
    tests_run++;
    if (!ok || {rsp_quotient, rsp_id, rsp_err} !== {e.q, e.id, e.err}) begin
      tests_failed++;
      $display("FAIL mid_reset_rsp: valid=%b q=%h id=%0d err=%b, required q=%h id=%0d err=%b",
               ok, rsp_quotient, rsp_id, rsp_err, e.q, e.id, e.err);
    end
    $display("[TB] post-reset rsp id=%0d q=%h err=%b", rsp_id, rsp_quotient, rsp_err);
    @(negedge clk);
    tests_run++;
    if (sb.size() !== 0 || rsp_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain: left=%0d rsp_valid=%b, required 0 0", sb.size(), rsp_valid);
    end
  endtask

  initial begin
    test_reset;
    test_back_to_back;
    test_basic;
    test_zero_div;
    test_backpressure;
    test_timeout;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
